// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and repeat sequencer driving the accumulator ALU
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_opcode,
    input  logic [3:0] cmd_operand,
    input  logic [1:0] cmd_repeat,
    input  logic       flush,
    output logic [3:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic       issue_valid,
    output logic       busy,
    output logic       illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_RESET = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd9;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t      state, state_nxt;
    logic [9:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic [1:0]  rep_left, rep_nxt;
    logic [3:0]  opc_nxt, a_nxt;
    logic        iv_nxt, ill_nxt;
    logic        push, pop;
    logic [9:0]  head;
    logic [3:0]  head_op, head_opd;
    logic [1:0]  head_rep;
    logic        head_legal;

    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        return (p == LAST) ? '0 : p + ONE;
    endfunction

    assign cmd_ready  = rst & (count < DEPTH_W);
    assign push       = cmd_valid & cmd_ready & ~flush;
    assign busy       = issue_valid | (count != '0);

    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_op    = head[9:6];
    assign head_opd   = head[5:2];
    assign head_rep   = head[1:0];
    assign head_legal = (head_op == OP_NOP) || (head_op == OP_RESET) ||
                        (head_op == OP_ADD) || (head_op == OP_AND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Pop whenever the issue slot is free or finishing, so commands run back-to-back.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (rep_left == 2'd0) begin
                        if (count != '0) pop = 1'b1;
                        else             state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        opc_nxt = alu_opcode;
        a_nxt   = alu_a;
        iv_nxt  = issue_valid;
        rep_nxt = rep_left;
        ill_nxt = illegal;
        if (flush) begin
            opc_nxt = OP_NOP;
            a_nxt   = 4'd0;
            iv_nxt  = 1'b0;
            rep_nxt = 2'd0;
        end else if (pop) begin
            // Illegal opcodes still occupy their slot but are neutralised to NO-OP.
            opc_nxt = head_legal ? head_op : OP_NOP;
            a_nxt   = (head_legal && head_op != OP_RESET) ? head_opd : 4'd0;
            iv_nxt  = 1'b1;
            rep_nxt = head_rep;
            ill_nxt = illegal | ~head_legal;
        end else if (state == S_ISSUE && rep_left != 2'd0) begin
            rep_nxt = rep_left - 2'd1;
        end else if (state_nxt == S_IDLE) begin
            opc_nxt = OP_NOP;
            a_nxt   = 4'd0;
            iv_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_opcode  <= OP_NOP;
            alu_a       <= 4'd0;
            issue_valid <= 1'b0;
            rep_left    <= 2'd0;
            illegal     <= 1'b0;
        end else begin
            alu_opcode  <= opc_nxt;
            alu_a       <= a_nxt;
            issue_valid <= iv_nxt;
            rep_left    <= rep_nxt;
            illegal     <= ill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {cmd_opcode, cmd_operand, cmd_repeat};
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer directly upstream of the accumulator ALU breadboard. It buffers {opcode, operand, repeat} commands in a 4-entry FIFO and drives the ALU's `opcode` and `A` inputs from registers. Each command is held for exactly repeat+1 clock edges, so the accumulator performs that many operations. When no command is pending it forces NO-OP (4'b0000), so the ALU is never left parked in an ADD or AND state.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: upstream command present.
- `cmd_ready` output 1: the block accepts a command this cycle.
- `cmd_opcode` input 4: ALU opcode.
- `cmd_operand` input 4: operand for ALU input A.
- `cmd_repeat` input 2: issue count minus one (0..3).
- `flush` input 1: synchronous; discards all pending and in-flight commands.
- `alu_opcode` output 4: registered; drives the ALU opcode.
- `alu_a` output 4: registered; drives ALU input A.
- `issue_valid` output 1: registered; high while a command (not a filler NO-OP) is on `alu_opcode`.
- `busy` output 1: `issue_valid` OR FIFO non-empty.
- `illegal` output 1: sticky; set when an illegal opcode is popped.

## Operation
- **Push**
  - A push occurs at a posedge with `cmd_valid & cmd_ready & ~flush`.
  - `cmd_ready = rst & (count < DEPTH)`.
  - Full-and-pop in the same cycle does NOT admit a push; ready is low whenever full.
- **FIFO**
  - Read pointer, write pointer and count are each log2(DEPTH)+1 bits wide.
  - Pointers wrap modulo DEPTH.
  - Entry width is 10 bits.
- **States**
  - IDLE: outputs show NO-OP, `alu_a`=0, `issue_valid`=0.
  - IDLE→ISSUE at a posedge where count>0 and no flush. The head entry is popped and `rep_left` is loaded with `cmd_repeat`.
  - ISSUE: outputs hold the popped command.
  - At each posedge in ISSUE, if `rep_left`>0, decrement `rep_left`.
  - At each posedge in ISSUE, if `rep_left`==0 and count>0, pop the next entry back-to-back with no NO-OP gap.
  - At each posedge in ISSUE, if `rep_left`==0 and count==0, go to IDLE.
- **Legal opcodes:** 0 (NO-OP), 1 (RESET), 5 (ADD), 9 (AND).
  - Any other opcode is popped normally but issued as opcode 0 with `alu_a`=0.
  - It is still held for repeat+1 cycles with `issue_valid`=1.
  - It sets `illegal`=1 at the same edge.
  - `illegal` clears only on reset.
- **RESET opcode:** issued like any other command; `alu_a` is forced to 0.
- **Flush**
  - At a posedge with `flush`=1: count=0, both pointers=0, state=IDLE, outputs go to NO-OP/0, `issue_valid`=0.
  - Flush has priority over push and pop in the same cycle.
  - `illegal` is unaffected.
- **Reset (async, rst=0)**
  - Immediately: state=IDLE, pointers/count=0, `rep_left`=0.
  - Outputs: `alu_opcode`=0, `alu_a`=0, `issue_valid`=0, `busy`=0, `illegal`=0, `cmd_ready`=0.
  - Reset mid-issue abandons the command.

## Timing
- **Latency:** command pushed at edge E0 appears on `alu_opcode` after E1 if IDLE. The ALU accumulator samples it at E2..E(2+repeat).
- **Back-to-back:** consecutive commands occupy consecutive cycle windows with no bubbles.
- **Throughput:** one command per repeat+1 cycles.
- **Outputs:** all ALU-facing outputs are register outputs. `cmd_ready` and `busy` are combinational from state and count.
- **Reset release:** first push is possible at the first posedge after `rst` rises.

## Test plan
- **Reset:** assert `rst`=0 mid-cycle while issuing ADD → outputs 0, `illegal`=0, `cmd_ready`=0 asynchronously; after release `cmd_ready`=1 and NO-OP is held indefinitely.
- **Accumulate:**
  - Push {1,0,0}; push {5,4'b0001,2}.
  - Required: `alu_opcode` shows 1 for 1 cycle, then 5 for 3 cycles, then returns to 0.
  - Downstream accumulator reads 0011 and stays at 0011.
- **Full FIFO:**
  - Hold `cmd_valid` with repeat=3 commands.
  - Required: exactly 4 accepted while the first is issuing (5 total in flight); `cmd_ready` goes low; `cmd_ready` rises exactly once per pop.
  - Ordering is preserved across pointer wrap (push 9 commands in total, check issue order).
- **Illegal opcode:** push {7,4'b1111,1} → `alu_opcode`=0, `alu_a`=0, `issue_valid`=1 for 2 cycles; `illegal`=1 and stays at 1.
- **Flush:**
  - Setup: 3 queued commands; assert `flush` with `cmd_valid`=1 in the same cycle.
  - Required next cycle: NO-OP, `busy`=0, count 0, pushed command dropped.
- **Mixed:** push {9,4'b1011,0} after ADD 1111 → AND result 1011 on the accumulator, followed by NO-OP.
